// File: rtl/sd_sector_dma.sv
// sd_sector_dma
// AHB master DMA that copies whole sectors between the SD sector buffer and system memory.
// DIR=0 moves buffer -> memory, DIR=1 moves memory -> buffer, one single NONSEQ word at a time.
// The CPU programs it over APB and a level interrupt reports completion or bus error.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB slave (offset in paddr[4:0])
//   haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock/hexcl : AHB master address/control
//   hready/hresp/hwdata/hrdata                              : AHB handshake and data
//   buf_addr/buf_re/buf_rdata/buf_we/buf_wdata              : sector buffer port (1-cycle read)
//   irq                                                     : IRQ_EN & (DONE | ERR), registered
module sd_sector_dma #(
  parameter int unsigned BUF_AW = 10,
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [15:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic              hexcl,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata,
  output logic [BUF_AW-1:0] buf_addr,
  output logic              buf_re,
  input  logic [W_DATA-1:0] buf_rdata,
  output logic              buf_we,
  output logic [W_DATA-1:0] buf_wdata,
  output logic              irq
);

  localparam logic [1:0]        HtransIdle   = 2'b00;
  localparam logic [1:0]        HtransNonseq = 2'b10;
  localparam logic [BUF_AW:0]   CntOne       = 1;
  localparam logic [BUF_AW-1:0] BufOne       = 1;
  localparam logic [W_ADDR-1:0] MemStep      = 4;

  typedef enum logic [3:0] {
    StIdle, StFetch, StBufRd, StBufLat, StAddr, StData, StBufWr, StDone, StErr
  } state_e;

  state_e              state_q;
  logic                dir_q, irq_en_q, done_q, err_q;
  logic [W_ADDR-1:0]   mem_addr_q, cur_mem_q;
  logic [BUF_AW-1:0]   buf_addr_q, cur_buf_q;
  logic [BUF_AW:0]     count_q, remain_q;
  logic [W_DATA-1:0]   data_q;
  logic [31:0]         rd_data;
  logic                apb_access, apb_wr, apb_rd, busy, start, word_done;
  logic                unused_paddr;

  assign pslverr   = 1'b0;
  assign hsize     = 3'b010;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hmastlock = 1'b0;
  assign hexcl     = 1'b0;
  assign haddr     = cur_mem_q;
  assign buf_addr  = cur_buf_q;
  // One data register serves as write data in both directions.
  assign hwdata    = data_q;
  assign buf_wdata = data_q;
  assign unused_paddr = ^paddr[15:5];

  // pready is part of the access term so each access is seen exactly once.
  assign apb_access = psel & penable & ~pready;
  assign apb_wr     = apb_access & pwrite;
  assign apb_rd     = apb_access & ~pwrite;
  assign busy       = (state_q != StIdle);
  assign start      = apb_wr && (paddr[4:0] == 5'h00) && pwdata[0] && !busy;
  assign word_done  = ((state_q == StData) && hready && !hresp && !dir_q) ||
                      (state_q == StBufWr);

  always_comb begin
    rd_data = '0;
    case (paddr[4:0])
      5'h00:   rd_data = {29'b0, irq_en_q, dir_q, 1'b0};
      5'h04:   rd_data = {29'b0, err_q, done_q, busy};
      5'h08:   rd_data = 32'(mem_addr_q);
      5'h0C:   rd_data = 32'(buf_addr_q);
      5'h10:   rd_data = 32'(count_q);
      5'h14:   rd_data = 32'(remain_q);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      cur_mem_q  <= '0;
      buf_addr_q <= '0;
      cur_buf_q  <= '0;
      count_q    <= '0;
      remain_q   <= '0;
      data_q     <= '0;
      pready     <= 1'b0;
      prdata     <= '0;
      htrans     <= HtransIdle;
      hwrite     <= 1'b0;
      buf_re     <= 1'b0;
      buf_we     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      pready <= apb_access;
      prdata <= apb_rd ? rd_data : '0;
      irq    <= irq_en_q & (done_q | err_q);

      // Configuration is frozen while a transfer runs.
      if (apb_wr && !busy) begin
        case (paddr[4:0])
          5'h00: begin
            dir_q    <= pwdata[1];
            irq_en_q <= pwdata[2];
          end
          5'h08:   mem_addr_q <= {pwdata[W_ADDR-1:2], 2'b00};
          5'h0C:   buf_addr_q <= pwdata[BUF_AW-1:0];
          // COUNT holds 0..2^BUF_AW; larger writes keep only the low bits.
          5'h10:   count_q    <= pwdata[BUF_AW:0];
          default: ;
        endcase
      end

      // W1C is honoured even while busy; an FSM set below in the same cycle wins.
      if (apb_wr && (paddr[4:0] == 5'h04)) begin
        if (pwdata[1]) done_q <= 1'b0;
        if (pwdata[2]) err_q  <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cur_mem_q <= mem_addr_q;
            cur_buf_q <= buf_addr_q;
            remain_q  <= count_q;
            state_q   <= StFetch;
          end
        end
        StFetch: begin
          if (remain_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (dir_q) begin
            htrans  <= HtransNonseq;
            hwrite  <= 1'b0;
            state_q <= StAddr;
          end else begin
            buf_re  <= 1'b1;
            state_q <= StBufRd;
          end
        end
        StBufRd: begin
          buf_re  <= 1'b0;
          state_q <= StBufLat;
        end
        StBufLat: begin
          data_q  <= buf_rdata;
          htrans  <= HtransNonseq;
          hwrite  <= 1'b1;
          state_q <= StAddr;
        end
        StAddr: begin
          if (hready) begin
            htrans  <= HtransIdle;
            state_q <= StData;
          end
        end
        StData: begin
          if (hready) begin
            if (hresp) begin
              state_q <= StErr;
            end else if (dir_q) begin
              data_q  <= hrdata;
              buf_we  <= 1'b1;
              state_q <= StBufWr;
            end
          end
        end
        StBufWr: buf_we <= 1'b0;
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        StErr: begin
          err_q   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Word completion: advance pointers and chain straight into the next word.
      if (word_done) begin
        cur_mem_q <= cur_mem_q + MemStep;
        cur_buf_q <= cur_buf_q + BufOne;
        remain_q  <= remain_q - CntOne;
        if (remain_q == CntOne) begin
          state_q <= StDone;
        end else if (dir_q) begin
          htrans  <= HtransNonseq;
          hwrite  <= 1'b0;
          state_q <= StAddr;
        end else begin
          buf_re  <= 1'b1;
          state_q <= StBufRd;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_dma.sv
// Scoreboard bench for sd_sector_dma: stimulus pushes expected AHB writes, buffer writes and
// APB read data into queues; monitors pop and compare when the DUT presents each event.
module tb_sd_sector_dma;
  localparam int BUF_AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock, hexcl;
  logic        hready, hresp;
  logic [31:0] hwdata, hrdata;
  logic [BUF_AW-1:0] buf_addr;
  logic        buf_re, buf_we;
  logic [31:0] buf_rdata, buf_wdata;
  logic        irq;

  always #5 clk = ~clk;

  sd_sector_dma #(.BUF_AW(BUF_AW), .W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hmastlock(hmastlock), .hexcl(hexcl), .hready(hready), .hresp(hresp), .hwdata(hwdata),
    .hrdata(hrdata), .buf_addr(buf_addr), .buf_re(buf_re), .buf_rdata(buf_rdata),
    .buf_we(buf_we), .buf_wdata(buf_wdata), .irq(irq)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] q_ahb_addr[$], q_ahb_data[$];
  logic [31:0] q_buf_addr[$], q_buf_data[$];
  logic [31:0] q_apb[$];
  string       q_apb_name[$];

  int ws = 0;
  int err_at = -1;
  int xfer_idx = 0;
  int nonseq_cnt = 0;
  int first_act = -1;
  int last_act = -1;

  logic [31:0] bufmem [1024];
  logic [31:0] s_a, s_wd;
  logic        s_w, s_e;
  logic [BUF_AW-1:0] r_ad;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sector buffer model: fixed contents, 1-cycle read latency.
  initial begin
    buf_rdata = '0;
    forever begin
      @(negedge clk);
      if (buf_re) begin
        r_ad = buf_addr;
        @(posedge clk);
        #1;
        buf_rdata = bufmem[r_ad];
      end
    end
  end

  // Monitors for buffer writes, APB read data and bus activity.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (htrans == 2'b10) nonseq_cnt++;
      if ((buf_re || buf_we || htrans == 2'b10) && first_act < 0) first_act = cyc;
      if (buf_we) begin
        last_act = cyc;
        if (q_buf_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL buf_wr_unexpected: got write to %0d expected none", buf_addr);
        end else begin
          chk("buf_wr_addr", 32'(buf_addr), q_buf_addr.pop_front());
          chk("buf_wr_data", buf_wdata, q_buf_data.pop_front());
        end
      end
      if (pready && psel && !pwrite) begin
        if (q_apb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL apb_rd_unexpected: got %08h expected none", prdata);
        end else begin
          chk(q_apb_name.pop_front(), prdata, q_apb.pop_front());
        end
      end
    end
  end

  // AHB slave: memory contents from memf, ws wait states, optional error on word err_at.
  initial begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && htrans == 2'b10) begin
        s_a = haddr;
        s_w = hwrite;
        s_e = (xfer_idx == err_at);
        xfer_idx++;
        @(posedge clk);
        #1;
        s_wd = hwdata;
        if (s_e) begin
          hready = 1'b0;
          hresp  = 1'b1;
          @(posedge clk);
          #1;
          hready = 1'b1;
          @(posedge clk);
          #1;
          hresp = 1'b0;
        end else begin
          for (int k = 0; k < ws; k++) begin
            hready = 1'b0;
            @(posedge clk);
            #1;
          end
          hready = 1'b1;
          hrdata = s_w ? 32'h0 : memf(s_a);
          @(posedge clk);
          #1;
          if (s_w) begin
            last_act = cyc - 1;
            if (q_ahb_addr.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL ahb_wr_unexpected: got addr %08h expected none", s_a);
            end else begin
              chk("ahb_wr_addr", s_a, q_ahb_addr.pop_front());
              chk("ahb_wr_data", s_wd, q_ahb_data.pop_front());
            end
          end
        end
      end
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic apb(input logic wr, input logic [4:0] off, input logic [31:0] wd);
    int n;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {11'b0, off}; pwdata = wd;
    @(posedge clk);
    #1;
    penable = 1'b1;
    n = 0;
    while (!pready && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!pready) begin
      checks++;
      errors++;
      $display("FAIL apb_timeout: got no pready expected pready within 8 cycles");
    end
    @(posedge clk);
    #1;
    psel = 1'b0;
    penable = 1'b0;
    chk("pready_pulse", 32'(pready), 32'd0);
  endtask

  task automatic apb_wr(input logic [4:0] off, input logic [31:0] d);
    apb(1'b1, off, d);
  endtask

  task automatic apb_rd(input string name, input logic [4:0] off, input logic [31:0] exp);
    q_apb.push_back(exp);
    q_apb_name.push_back(name);
    apb(1'b0, off, 32'h0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Program and start a transfer; expected events for the first ok_words words are queued.
  task automatic run_xfer(input logic dir, input logic [31:0] mem, input int ba, input int cnt,
                          input int wsv, input logic irqen, input int ok_words);
    logic [31:0] a;
    int b;
    ws = wsv;
    xfer_idx = 0;
    apb_wr(5'h08, mem);
    apb_wr(5'h0C, 32'(ba));
    apb_wr(5'h10, 32'(cnt));
    for (int i = 0; i < ok_words; i++) begin
      a = (mem & 32'hFFFF_FFFC) + 32'(4 * i);
      b = (ba + i) % 1024;
      if (!dir) begin
        q_ahb_addr.push_back(a);
        q_ahb_data.push_back(bufmem[b]);
      end else begin
        q_buf_addr.push_back(32'(b));
        q_buf_data.push_back(memf(a));
      end
    end
    first_act = -1;
    apb_wr(5'h00, {29'b0, irqen, dir, 1'b1});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q_ahb_addr.size() != 0 || q_buf_addr.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d events pending expected 0",
               q_ahb_addr.size() + q_buf_addr.size());
    end
    step(4);
  endtask

  initial begin
    int nc, n;
    logic d, ie;
    logic [31:0] m;
    int ba, cnt, w;
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, n, ba, cnt, w;
    logic d, ie;
    logic [31:0] m;
    for (int i = 0; i < 1024; i++) bufmem[i] = 32'(i) * 32'h0101_0101;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    // Reset state
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_bufre_we", {30'b0, buf_re, buf_we}, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("const_ahb_ctl", {17'b0, hsize, hburst, hprot, hmastlock, hexcl, pslverr},
        {17'b0, 3'b010, 3'b000, 4'b0011, 3'b000});
    apb_rd("rst_ctrl", 5'h00, 32'h0);
    apb_rd("rst_status", 5'h04, 32'h0);
    apb_rd("rst_remain", 5'h14, 32'h0);

    // Buffer -> memory, 128 words, zero wait states; low address bits are dropped
    run_xfer(1'b0, 32'h0000_2003, 0, 128, 0, 1'b0, 128);
    wait_drain(700);
    chk("dir0_cycles", 32'(last_act - first_act + 1), 32'd512);
    apb_rd("dir0_status", 5'h04, 32'h2);
    apb_rd("dir0_remain", 5'h14, 32'h0);
    apb_rd("mem_addr_rb", 5'h08, 32'h2000);
    apb_rd("unmapped_rd", 5'h18, 32'h0);

    // Memory -> buffer, 4 words, 2 wait states each
    run_xfer(1'b1, 32'h0000_8000, 16, 4, 2, 1'b0, 4);
    wait_drain(200);
    chk("dir1_cycles", 32'(last_act - first_act + 1), 32'd20);
    apb_rd("dir1_status", 5'h04, 32'h2);

    // Buffer index and memory address wrap
    run_xfer(1'b1, 32'hFFFF_FFF8, 1022, 4, 0, 1'b0, 4);
    wait_drain(200);
    run_xfer(1'b0, 32'h0000_1000, 1022, 4, 1, 1'b0, 4);
    wait_drain(200);
    apb_rd("wrap_bufaddr_rb", 5'h0C, 32'd1022);

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      d   = 1'($urandom_range(0, 1));
      m   = $urandom;
      ba  = int'($urandom_range(0, 1023));
      cnt = int'($urandom_range(1, 12));
      w   = int'($urandom_range(0, 2));
      ie  = 1'($urandom_range(0, 1));
      run_xfer(d, m, ba, cnt, w, ie, cnt);
      wait_drain(cnt * (4 + w) + 60);
      apb_rd("rand_status", 5'h04, 32'h2);
      apb_rd("rand_remain", 5'h14, 32'h0);
      apb_rd("rand_count", 5'h10, 32'(cnt));
      chk("rand_irq", 32'(irq), 32'(ie));
    end

    // Bus error on the third word
    err_at = 2;
    run_xfer(1'b0, 32'h0000_4000, 100, 8, 0, 1'b1, 2);
    n = 0;
    while (!irq && n < 200) begin
      step(1);
      n++;
    end
    chk("err_irq", 32'(irq), 32'd1);
    chk("err_htrans", 32'(htrans), 32'd0);
    apb_rd("err_status", 5'h04, 32'h4);
    apb_rd("err_remain", 5'h14, 32'd6);
    apb_wr(5'h04, 32'h4);
    step(2);
    chk("err_irq_clr", 32'(irq), 32'd0);
    apb_rd("err_status_clr", 5'h04, 32'h0);
    err_at = -1;

    // COUNT=0: done next cycle, no bus activity
    nc = nonseq_cnt;
    apb_wr(5'h10, 32'h0);
    apb_wr(5'h00, 32'h5);
    chk("cnt0_irq_e1", 32'(irq), 32'd0);
    step(1);
    chk("cnt0_irq_e2", 32'(irq), 32'd1);
    apb_rd("cnt0_status", 5'h04, 32'h2);
    chk("cnt0_no_bus", 32'(nonseq_cnt - nc), 32'd0);

    // Writes while busy are ignored
    run_xfer(1'b1, 32'h0000_3000, 200, 10, 1, 1'b0, 10);
    apb_rd("busy_status", 5'h04, 32'h1);
    apb_wr(5'h10, 32'd3);
    apb_wr(5'h08, 32'h0000_9000);
    apb_wr(5'h00, 32'h1);
    apb_rd("busy_count", 5'h10, 32'd10);
    wait_drain(200);
    apb_rd("busy_mem_rb", 5'h08, 32'h3000);
    apb_rd("busy_status_end", 5'h04, 32'h2);

    // Reset in the address phase
    apb_wr(5'h08, 32'h0000_5000);
    apb_wr(5'h0C, 32'd5);
    apb_wr(5'h10, 32'd8);
    apb_wr(5'h00, 32'h5);
    n = 0;
    while (htrans != 2'b10 && n < 20) begin
      step(1);
      n++;
    end
    chk("rst_reach_addr", 32'(htrans), 32'h2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_htrans", 32'(htrans), 32'd0);
    chk("midrst_irq_re", {30'b0, irq, buf_re}, 32'd0);
    apb_rd("midrst_ctrl", 5'h00, 32'h0);
    apb_rd("midrst_status", 5'h04, 32'h0);
    apb_rd("midrst_mem", 5'h08, 32'h0);
    apb_rd("midrst_buf", 5'h0C, 32'h0);
    apb_rd("midrst_count", 5'h10, 32'h0);
    apb_rd("midrst_remain", 5'h14, 32'h0);
    step(5);

    chk("ahb_queue_drained", 32'(q_ahb_addr.size()), 32'd0);
    chk("buf_queue_drained", 32'(q_buf_addr.size()), 32'd0);
    chk("apb_queue_drained", 32'(q_apb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_sector_dma.md
Name: sd_sector_dma

Overview:
- AHB5 master DMA engine that moves whole sectors between the SD block's local sector buffer and system memory.
- Sits directly downstream of the SD host wrapper. After the SD controller fills the buffer on a read, this block copies the buffer into RAM; before a write, it fills the buffer from RAM.
- Programmed by the CPU over APB; raises a level interrupt on completion or bus error.

Parameters:
- BUF_AW, 10, word-address width of the sector buffer port.
- W_ADDR, 32, AHB address width.
- W_DATA, 32, AHB data width (fixed 32).

Ports:
- clk in 1: system clock.
- rst in 1: reset.
- psel, penable, pwrite in 1 each: APB control.
- paddr in 16: APB address; offset in paddr[4:0].
- pwdata in 32: APB write data.
- prdata out 32: APB read data.
- pready out 1: APB ready.
- pslverr out 1: APB error; tied 0.
- haddr out W_ADDR: AHB address.
- hwrite out 1: AHB write.
- htrans out 2: AHB transfer type.
- hsize out 3: AHB size.
- hburst out 3: AHB burst; always 0 (SINGLE).
- hprot out 4: AHB protection; constant 4'b0011.
- hmastlock out 1: always 0.
- hexcl out 1: always 0.
- hready in 1: AHB ready.
- hresp in 1: AHB error response.
- hwdata out 32: AHB write data.
- hrdata in 32: AHB read data.
- buf_addr out BUF_AW: sector buffer word address.
- buf_re out 1: buffer read enable; 1-cycle read latency.
- buf_rdata in 32: buffer read data.
- buf_we out 1: buffer write enable.
- buf_wdata out 32: buffer write data.
- irq out 1: interrupt, level.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: all regs 0; htrans=IDLE; hwrite=0; pready=0; prdata=0; buf_re=0; buf_we=0; irq=0; state IDLE.
- Reset mid-transfer: next edge forces htrans=IDLE and IDLE state. Any partial word is lost.
- APB registers:
  - 0x00 CTRL: bit0 START (write-1 pulse), bit1 DIR (0=buffer->mem, 1=mem->buffer), bit2 IRQ_EN.
  - 0x04 STATUS: bit0 BUSY (read-only), bit1 DONE (write-1-to-clear), bit2 ERR (write-1-to-clear).
  - 0x08 MEM_ADDR: bits[1:0] forced 0.
  - 0x0C BUF_ADDR: word index.
  - 0x10 COUNT: words, range 0..2^BUF_AW.
  - 0x14 REMAIN: read-only.
  - Unmapped offsets read 0; writes to them are ignored.
- APB timing: an access is psel&penable&!pready. pready pulses exactly 1 cycle, on the cycle after the access is detected; prdata is valid with it. Zero-wait otherwise.
- Writes while busy: writes to CTRL, MEM_ADDR, BUF_ADDR and COUNT while BUSY are ignored. STATUS W1C is always honoured.
- START with BUSY=0: clears DONE and ERR, loads working copies of the addresses and COUNT, then enters IDLE->FETCH. COUNT=0 sets DONE the next cycle with no bus activity.
- DIR=0 per-word sequence:
  - BUF_RD: buf_re=1, buf_addr=cur_buf.
  - BUF_LAT: capture buf_rdata into hwdata.
  - ADDR: htrans=NONSEQ, hwrite=1, hsize=2, haddr=cur_mem, held until hready=1.
  - DATA: htrans=IDLE, hwdata held until hready=1.
- DIR=1 per-word sequence:
  - ADDR: hwrite=0.
  - DATA: on hready=1, capture hrdata.
  - BUF_WR: buf_we=1, buf_wdata=captured data, buf_addr=cur_buf.
- Per-word latency with zero wait states: 4 cycles for DIR=0, 3 cycles for DIR=1. Each hready-low cycle adds 1 cycle.
- Word completion (end of DATA for DIR=0, BUF_WR for DIR=1): cur_mem += 4 (wraps mod 2^32); cur_buf += 1 (wraps mod 2^BUF_AW); REMAIN -= 1. REMAIN=0 -> DONE, else the next word starts immediately.
- Error: hresp=1 in DATA phase aborts the transfer. On the cycle hready=1 the block enters ERR: sets ERR, BUSY=0, no buffer write for that word. REMAIN keeps the count including the failed word.
- DONE state: sets DONE, BUSY=0, returns to IDLE.
- irq = IRQ_EN & (DONE | ERR), registered.
- Simultaneous events: START written in the same cycle DONE is being set is ignored, because BUSY is still 1.

Test Plan:
- DIR=0, MEM_ADDR=0x2000, BUF_ADDR=0, COUNT=128, buffer holds i*0x01010101, zero-wait slave -> 128 single NONSEQ writes to 0x2000..0x21FC with matching data; DONE=1 after 512 cycles; REMAIN=0.
- DIR=1, COUNT=4, slave inserts 2 wait states per data phase, memory words A0..A3 -> buffer words 0..3 written A0..A3, one buf_we pulse each; total 20 cycles.
- BUF_ADDR=1022, COUNT=4 -> buf_addr sequence 1022, 1023, 0, 1.
- hresp error on the 3rd word of COUNT=8, IRQ_EN=1 -> ERR=1, irq=1, REMAIN=6, htrans IDLE afterwards; STATUS write 0x4 clears irq.
- COUNT=0 START -> DONE next cycle, htrans never leaves IDLE. START and COUNT write while busy -> ignored.
- rst asserted for 1 cycle mid-ADDR phase -> htrans=IDLE, BUSY=0, all registers 0 next cycle.
